// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: FSM states, initial hash, round constants, f() and rotates.
package sha1_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROUND,
        S_UPDATE,
        S_WAIT,
        S_DONE
    } sha1_state_e;

    localparam logic [159:0] H_INIT = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                       32'h10325476, 32'hC3D2E1F0};

    localparam logic [31:0] K_00_19 = 32'h5A827999;
    localparam logic [31:0] K_20_39 = 32'h6ED9EBA1;
    localparam logic [31:0] K_40_59 = 32'h8F1BBCDC;
    localparam logic [31:0] K_60_79 = 32'hCA62C1D6;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] rotl5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] rotl30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

    function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        if (t < 7'd20)      return (b & c) | (~b & d);
        else if (t < 7'd40) return b ^ c ^ d;
        else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
        else                return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] sha1_k(input logic [6:0] t);
        if (t < 7'd20)      return K_00_19;
        else if (t < 7'd40) return K_20_39;
        else if (t < 7'd60) return K_40_59;
        else                return K_60_79;
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/sha1_wsched.sv
// SHA-1 message schedule: 16-entry circular buffer, W for step t, written back in place.
module sha1_wsched
    import sha1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        step_en,
    input  logic [6:0]  t,
    input  logic [31:0] data_in,
    output logic [31:0] w
);

    logic [15:0][31:0] wbuf;
    logic [3:0]        i0, i2, i8, i13;

    assign i0  = t[3:0];
    assign i2  = t[3:0] + 4'd2;   // slot of W[t-14]
    assign i8  = t[3:0] + 4'd8;   // slot of W[t-8]
    assign i13 = t[3:0] + 4'd13;  // slot of W[t-3]

    always_comb begin
        w = data_in;
        if (t >= 7'd16)
            w = rotl1(wbuf[i13] ^ wbuf[i8] ^ wbuf[i2] ^ wbuf[i0]);
    end

    always_ff @(posedge clk) begin
        if (reset)
            wbuf <= '0;
        else if (step_en)
            wbuf[i0] <= w;
    end

endmodule

// File: rtl/sha1_compress.sv
// SHA-1 block compression with chaining state and digest hold.
// Define SHA1_HASH_LE_OUT_EN to byte-swap each 32-bit word of hash.
module sha1_compress
    import sha1_pkg::*;
#(
    parameter int LAST_ROUND = 83
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         compute_enable,
    input  logic [7:0]   round,
    input  logic [31:0]  data_in,
    input  logic         finish,
    output logic [159:0] hash,
    output logic         hash_valid,
    output logic         busy
);

    // WAIT must see compute_enable high at least once after UPDATE.
    if (LAST_ROUND < 81) begin : g_last_round_check
        $error("sha1_compress: LAST_ROUND must be at least 81");
    end

    sha1_state_e      st, nxt;
    logic [0:4][31:0] h;
    logic [31:0]      a, b, c, d, e;
    logic [6:0]       cnt;

    logic             step_en, upd_en;
    logic [6:0]       t_val;
    logic [31:0]      sa, sb, sc, sd, se;
    logic [31:0]      w, tmp;

    // Step 0 runs in IDLE straight from H so the block needs no preload cycle.
    assign t_val = (st == S_IDLE) ? 7'd0 : cnt;

    always_comb begin
        {sa, sb, sc, sd, se} = {a, b, c, d, e};
        if (st == S_IDLE)
            {sa, sb, sc, sd, se} = h;
    end

    assign tmp = rotl5(sa) + sha1_f(t_val, sb, sc, sd) + se + sha1_k(t_val) + w;

    sha1_wsched u_wsched (
        .clk     (clk),
        .reset   (reset),
        .step_en (step_en),
        .t       (t_val),
        .data_in (data_in),
        .w       (w)
    );

    always_comb begin
        nxt     = st;
        step_en = 1'b0;
        upd_en  = 1'b0;
        case (st)
            S_IDLE: begin
                if (compute_enable && round == 8'd0) begin
                    step_en = 1'b1;
                    nxt     = S_ROUND;
                end
            end
            S_ROUND: begin
                if (!compute_enable || round != {1'b0, cnt}) begin
                    nxt = S_IDLE;
                end else begin
                    step_en = 1'b1;
                    if (cnt == 7'd79)
                        nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                upd_en = 1'b1;
                nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (!compute_enable)
                    nxt = finish ? S_DONE : S_IDLE;
            end
            S_DONE: nxt = S_DONE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= S_IDLE;
            h   <= H_INIT;
            a   <= '0;
            b   <= '0;
            c   <= '0;
            d   <= '0;
            e   <= '0;
            cnt <= '0;
        end else begin
            st <= nxt;
            if (step_en) begin
                a   <= tmp;
                b   <= sa;
                c   <= rotl30(sb);
                d   <= sc;
                e   <= sd;
                cnt <= t_val + 7'd1;
            end
            if (upd_en) begin
                h[0] <= h[0] + a;
                h[1] <= h[1] + b;
                h[2] <= h[2] + c;
                h[3] <= h[3] + d;
                h[4] <= h[4] + e;
            end
        end
    end

`ifdef SHA1_HASH_LE_OUT_EN
    assign hash = {bswap32(h[0]), bswap32(h[1]), bswap32(h[2]), bswap32(h[3]), bswap32(h[4])};
`else
    assign hash = h;
`endif

    assign hash_valid = (st == S_DONE);
    assign busy       = (st == S_ROUND) || (st == S_UPDATE);

endmodule
